// File: rtl/msi_bus_arbiter_if.sv
// Shared snooping-bus signal bundle between the cache controllers and the
// round-robin bus arbiter. The master modport is the requester/memory side,
// the slave modport is the arbiter itself.
interface msi_bus_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 9,
    parameter int OWN_W   = 2
);
    logic [NUM_REQ-1:0]        req;
    logic [2*NUM_REQ-1:0]      req_op;
    logic [ADDR_W*NUM_REQ-1:0] req_addr;
    logic                      txn_done;
    logic [NUM_REQ-1:0]        gnt;
    logic                      bus_valid;
    logic [1:0]                bus_op;
    logic [ADDR_W-1:0]         bus_addr;
    logic [OWN_W-1:0]          bus_owner;
    logic [NUM_REQ-1:0]        cplt;
    logic                      bus_error;

    modport master (
        output req, req_op, req_addr, txn_done,
        input  gnt, bus_valid, bus_op, bus_addr, bus_owner, cplt, bus_error
    );

    modport slave (
        input  req, req_op, req_addr, txn_done,
        output gnt, bus_valid, bus_op, bus_addr, bus_owner, cplt, bus_error
    );
endinterface

// File: rtl/msi_bus_arbiter.sv
// Round-robin arbiter/sequencer for the MSI snooping bus.
// One owner at a time: IDLE -> BCAST (one-cycle broadcast) -> WAIT (until
// txn_done) -> RELEASE (cplt pulse to the owner) -> IDLE.
// Optional macro ARB_TIMEOUT_EN bounds WAIT to TIMEOUT_CYC cycles and flags
// an abort on bus_error alongside the cplt pulse.
module msi_bus_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 9,
    parameter int OWN_W       = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    msi_bus_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, BCAST, WAIT, RELEASE} state_t;

    state_t             state_reg, state_next;
    logic [OWN_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [OWN_W-1:0]   owner_reg, owner_next;
    logic [1:0]         op_reg, op_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;

    // Candidate index for each rotation offset, its request bit, and the
    // per-requester op/address slices.
    logic [OWN_W-1:0]   cand     [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;
    logic [1:0]         op_arr   [NUM_REQ];
    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0] owner_dec;
    logic [OWN_W-1:0]   winner;
    logic               found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            // Offset gi looks at requester (rr_ptr + 1 + gi) mod NUM_REQ.
            logic [OWN_W:0] sum;
            logic [OWN_W:0] wrapped;
            assign sum         = {1'b0, rr_ptr_reg} + (OWN_W+1)'(gi + 1);
            assign wrapped     = (sum >= (OWN_W+1)'(NUM_REQ)) ? sum - (OWN_W+1)'(NUM_REQ) : sum;
            assign cand[gi]    = wrapped[OWN_W-1:0];
            assign cand_hit[gi] = bus.req[cand[gi]];
            assign op_arr[gi]   = bus.req_op[2*gi+1:2*gi];
            assign addr_arr[gi] = bus.req_addr[ADDR_W*(gi+1)-1:ADDR_W*gi];
            assign owner_dec[gi] = (owner_reg == OWN_W'(gi));
        end
    endgenerate

    // Pick the lowest rotation offset with a pending request.
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner = cand[k];
            end
        end
        found = |cand_hit;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;
`endif

    // Next-state and latched bus-value logic.
    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        owner_next  = owner_reg;
        op_next     = op_reg;
        addr_next   = addr_reg;
`ifdef ARB_TIMEOUT_EN
        cnt_next    = cnt_reg;
        err_next    = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next  = BCAST;
                    rr_ptr_next = winner;
                    owner_next  = winner;
                    op_next     = op_arr[winner];
                    addr_next   = addr_arr[winner];
                end
            end
            BCAST: begin
                // txn_done deliberately ignored: snoopers only now see the op.
                state_next = WAIT;
`ifdef ARB_TIMEOUT_EN
                cnt_next   = '0;
                err_next   = 1'b0;
`endif
            end
            WAIT: begin
                if (bus.txn_done) begin
                    state_next = RELEASE;
`ifdef ARB_TIMEOUT_EN
                    err_next   = 1'b0;
                end else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_next = RELEASE;
                    err_next   = 1'b1;
                end else begin
                    cnt_next   = cnt_reg + CNT_W'(1);
`endif
                end
            end
            RELEASE: begin
                state_next = IDLE;
`ifdef ARB_TIMEOUT_EN
                err_next   = 1'b0;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // State and latched bus registers; reset aborts any transaction silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= OWN_W'(NUM_REQ - 1);
            owner_reg  <= '0;
            op_reg     <= '0;
            addr_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            owner_reg  <= owner_next;
            op_reg     <= op_next;
            addr_reg   <= addr_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // WAIT-cycle counter and abort flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            err_reg <= err_next;
        end
    end
    assign bus.bus_error = (state_reg == RELEASE) && err_reg;
`else
    assign bus.bus_error = 1'b0;
`endif

    // Outputs decode straight from registered state, so they are glitch-free.
    assign bus.gnt       = (state_reg == BCAST || state_reg == WAIT) ? owner_dec : '0;
    assign bus.cplt      = (state_reg == RELEASE) ? owner_dec : '0;
    assign bus.bus_valid = (state_reg == BCAST);
    assign bus.bus_op    = op_reg;
    assign bus.bus_addr  = addr_reg;
    assign bus.bus_owner = owner_reg;
endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Directed bench for msi_bus_arbiter with a grant scoreboard.
module tb_msi_bus_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 9;
    localparam int OWN_W   = 2;

    typedef struct {
        int         owner;
        logic [1:0] op;
        logic [8:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    int         cur_owner;
    logic [1:0] cur_op;
    logic [8:0] cur_addr;

    msi_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .OWN_W(OWN_W)) bus_if ();

    msi_bus_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .OWN_W(OWN_W), .TIMEOUT_CYC(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [1:0] op, input logic [8:0] addr);
        bus_if.req_op[2*i +: 2]          = op;
        bus_if.req_addr[ADDR_W*i +: ADDR_W] = addr;
    endtask

    task automatic push_exp(input int owner, input logic [1:0] op, input logic [8:0] addr);
        exp_t e;
        e.owner = owner;
        e.op    = op;
        e.addr  = addr;
        exp_q.push_back(e);
    endtask

    // Advance until the broadcast strobe, then compare against the scoreboard.
    task automatic grant_phase();
        exp_t e;
        int   n;
        n = 0;
        tick();
        while (bus_if.bus_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk("bus_valid_seen", 32'(bus_if.bus_valid), 32'd1);
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cur_owner = e.owner;
            cur_op    = e.op;
            cur_addr  = e.addr;
            chk("gnt", 32'(bus_if.gnt), 32'(4'b0001 << e.owner));
            chk("bus_owner", 32'(bus_if.bus_owner), 32'(e.owner));
            chk("bus_op", 32'(bus_if.bus_op), 32'(e.op));
            chk("bus_addr", 32'(bus_if.bus_addr), 32'(e.addr));
            chk("cplt_in_bcast", 32'(bus_if.cplt), 32'd0);
        end
    endtask

    // Step from BCAST into the first WAIT cycle.
    task automatic enter_wait();
        tick();
        chk("bus_valid_wait", 32'(bus_if.bus_valid), 32'd0);
        chk("gnt_wait", 32'(bus_if.gnt), 32'(4'b0001 << cur_owner));
    endtask

    // From a WAIT sample point: stay delay cycles, then complete.
    task automatic finish_phase(input int delay, input logic [3:0] req_after);
        for (int i = 0; i < delay; i++) begin
            chk("gnt_hold", 32'(bus_if.gnt), 32'(4'b0001 << cur_owner));
            chk("op_hold", 32'(bus_if.bus_op), 32'(cur_op));
            chk("addr_hold", 32'(bus_if.bus_addr), 32'(cur_addr));
            chk("cplt_wait", 32'(bus_if.cplt), 32'd0);
            tick();
        end
        bus_if.txn_done = 1'b1;
        tick();
        bus_if.txn_done = 1'b0;
        bus_if.req      = req_after;
        chk("cplt", 32'(bus_if.cplt), 32'(4'b0001 << cur_owner));
        chk("gnt_release", 32'(bus_if.gnt), 32'd0);
        chk("bus_error", 32'(bus_if.bus_error), 32'd0);
        chk("op_release", 32'(bus_if.bus_op), 32'(cur_op));
        chk("owner_release", 32'(bus_if.bus_owner), 32'(cur_owner));
        $display("txn owner=%0d op=%0d addr=%03h", cur_owner, cur_op, cur_addr);
        tick();
        chk("cplt_pulse_end", 32'(bus_if.cplt), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus_if.req      = '0;
        bus_if.req_op   = '0;
        bus_if.req_addr = '0;
        bus_if.txn_done = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        tick();
        // Reset state
        chk("rst_gnt", 32'(bus_if.gnt), 32'd0);
        chk("rst_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("rst_cplt", 32'(bus_if.cplt), 32'd0);
        chk("rst_op", 32'(bus_if.bus_op), 32'd0);
        chk("rst_addr", 32'(bus_if.bus_addr), 32'd0);
        chk("rst_owner", 32'(bus_if.bus_owner), 32'd0);
        chk("rst_error", 32'(bus_if.bus_error), 32'd0);
        reset = 1'b0;

        // Single requester 0, BusRdX to 0x0A5, done after a few WAIT cycles.
        set_src(0, 2'b01, 9'h0A5);
        bus_if.req = 4'b0001;
        push_exp(0, 2'b01, 9'h0A5);
        grant_phase();
        enter_wait();
        finish_phase(2, 4'b0000);

        // All four requesting continuously: round-robin 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            set_src(i, 2'(i), 9'(9'h100 + 9'(i * 17)));
        end
        bus_if.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_exp(k % NUM_REQ, 2'(k % NUM_REQ), 9'(9'h100 + 9'((k % NUM_REQ) * 17)));
        end
        for (int k = 0; k < 5; k++) begin
            grant_phase();
            chk("gnt_onehot", 32'($onehot(bus_if.gnt)), 32'd1);
            enter_wait();
            finish_phase(0, (k == 4) ? 4'b0000 : 4'b1111);
        end

        // Owner 2 changes op/addr and drops req during WAIT.
        set_src(2, 2'b10, 9'h1C3);
        bus_if.req = 4'b0100;
        push_exp(2, 2'b10, 9'h1C3);
        grant_phase();
        enter_wait();
        set_src(2, 2'b11, 9'h03C);
        bus_if.req = 4'b0000;
        finish_phase(3, 4'b0000);

        // txn_done in IDLE is ignored.
        bus_if.txn_done = 1'b1;
        tick();
        bus_if.txn_done = 1'b0;
        chk("idle_done_cplt", 32'(bus_if.cplt), 32'd0);
        chk("idle_done_gnt", 32'(bus_if.gnt), 32'd0);
        tick();
        chk("idle_done_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("idle_done_cplt2", 32'(bus_if.cplt), 32'd0);

        // txn_done in BCAST is ignored.
        set_src(0, 2'b00, 9'h012);
        bus_if.req = 4'b0001;
        push_exp(0, 2'b00, 9'h012);
        grant_phase();
        bus_if.txn_done = 1'b1;
        bus_if.req      = 4'b0000;
        tick();
        bus_if.txn_done = 1'b0;
        chk("bcast_done_cplt", 32'(bus_if.cplt), 32'd0);
        chk("bcast_done_gnt", 32'(bus_if.gnt), 32'b0001);
        chk("bcast_done_valid", 32'(bus_if.bus_valid), 32'd0);
        tick();
        chk("bcast_done_still_wait", 32'(bus_if.gnt), 32'b0001);
        finish_phase(0, 4'b0000);

        // Reset during WAIT with owner 1 aborts silently and restores priority.
        set_src(1, 2'b01, 9'h155);
        set_src(2, 2'b11, 9'h0EE);
        bus_if.req = 4'b0010;
        push_exp(1, 2'b01, 9'h155);
        grant_phase();
        enter_wait();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_gnt", 32'(bus_if.gnt), 32'd0);
        chk("midrst_cplt", 32'(bus_if.cplt), 32'd0);
        chk("midrst_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("midrst_owner", 32'(bus_if.bus_owner), 32'd0);
        bus_if.req = 4'b0110;
        push_exp(1, 2'b01, 9'h155);
        grant_phase();
        bus_if.req = 4'b0000;
        enter_wait();
        finish_phase(0, 4'b0000);

`ifdef ARB_TIMEOUT_EN
        // Timeout with no txn_done: abort after 16 WAIT cycles.
        set_src(3, 2'b10, 9'h1F0);
        bus_if.req = 4'b1000;
        push_exp(3, 2'b10, 9'h1F0);
        grant_phase();
        bus_if.req = 4'b0000;
        enter_wait();
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_cplt_wait", 32'(bus_if.cplt), 32'd0);
            chk("to_gnt_wait", 32'(bus_if.gnt), 32'b1000);
        end
        tick();
        chk("to_cplt", 32'(bus_if.cplt), 32'b1000);
        chk("to_error", 32'(bus_if.bus_error), 32'd1);
        $display("txn owner=3 op=2 addr=1f0 timeout");
        tick();
        chk("to_error_end", 32'(bus_if.bus_error), 32'd0);

        // txn_done on the timeout cycle wins.
        bus_if.req = 4'b1000;
        push_exp(3, 2'b10, 9'h1F0);
        grant_phase();
        bus_if.req = 4'b0000;
        enter_wait();
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        bus_if.txn_done = 1'b1;
        tick();
        bus_if.txn_done = 1'b0;
        chk("to_done_cplt", 32'(bus_if.cplt), 32'b1000);
        chk("to_done_error", 32'(bus_if.bus_error), 32'd0);
        $display("txn owner=3 op=2 addr=1f0 done-on-timeout");
        tick();
`endif

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/msi_bus_arbiter.md
Name: msi_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared snooping bus between NUM_REQ cache controllers, one per processor core.
- Grants one requester at a time and latches that requester's coherence op and 9-bit block address.
- Broadcasts the op and address to all snoopers for one cycle, then holds the bus until memory or the owning cache signals completion.
- Returns a one-cycle completion pulse to the granted requester.

Parameters:
- NUM_REQ, 4, number of requesting cache controllers (2..8).
- ADDR_W, 9, bus address width; matches the core address width.
- OWN_W, 2, width of the owner index; must be at least clog2(NUM_REQ).
- TIMEOUT_CYC, 16, cycles allowed in WAIT before abort; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester bus request, level.
- req_op  in  2*NUM_REQ  per-requester op, slice [2i+1:2i]: 00 BusRd, 01 BusRdX, 10 BusUpgr, 11 Flush.
- req_addr  in  ADDR_W*NUM_REQ  per-requester block address, slice [ADDR_W*(i+1)-1:ADDR_W*i].
- txn_done  in  1  completion strobe from memory or the supplying cache.
- gnt  out  NUM_REQ  one-hot grant; high from BCAST through WAIT.
- bus_valid  out  1  one-cycle broadcast strobe that snoopers sample.
- bus_op  out  2  latched op of the current owner.
- bus_addr  out  ADDR_W  latched address of the current owner.
- bus_owner  out  OWN_W  index of the current owner.
- cplt  out  NUM_REQ  one-cycle completion pulse to the owner.
- bus_error  out  1  abort indication; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset:
  - State goes to IDLE; all outputs go to 0.
  - rr_ptr goes to NUM_REQ-1, so requester 0 has highest priority first.
  - Reset mid-transaction aborts with no cplt pulse.
- FSM states: IDLE, BCAST, WAIT, RELEASE.
- IDLE:
  - If req is nonzero, pick the winner: first set bit searching upward from rr_ptr+1 modulo NUM_REQ.
  - Register the winner's gnt bit, bus_owner, bus_op and bus_addr; set rr_ptr to the winner; go to BCAST.
  - Latency is one cycle from req sampled high to gnt/bus_valid high.
- BCAST:
  - bus_valid=1 for exactly this one cycle; gnt held; go to WAIT.
  - txn_done is ignored in this state.
- WAIT:
  - gnt, bus_op, bus_addr and bus_owner stay stable; bus_valid=0.
  - On txn_done=1, go to RELEASE.
- RELEASE:
  - gnt=0; cplt[bus_owner]=1 for one cycle; go to IDLE.
  - bus_op, bus_addr and bus_owner keep their last values until the next grant.
- Minimum occupancy is 4 cycles per transaction (IDLE, BCAST, WAIT, RELEASE).
- A req still high in IDLE after RELEASE counts as a new request; the requester must drop req on its cplt cycle.
- req_op/req_addr changes after the grant are ignored; the values are latched at grant.
- Deasserting req during BCAST/WAIT does not abort; the transaction completes and cplt still pulses.
- txn_done in IDLE or RELEASE is ignored.
- Simultaneous requests resolve by round robin; a single persistent requester is re-granted on every IDLE visit.
- gnt is always zero or one-hot; cplt is at most one-hot.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC with no txn_done, go to RELEASE; bus_error=1 in the same cycle as the cplt pulse.
  - If txn_done arrives on the timeout cycle, it wins and bus_error=0.
- Undefined: no counter; WAIT is unbounded; bus_error is constant 0.

Test Plan:
- Reset, then req=4'b0001, op=01, addr=9'h0A5: gnt=0001 and bus_valid=1 one cycle later, bus_op=01, bus_addr=0A5, bus_owner=0. Drive txn_done 3 cycles later: cplt=0001 one cycle later for one cycle.
- req=4'b1111 held, txn_done 1 cycle after each WAIT entry: grant order 0,1,2,3,0; each gnt strictly one-hot.
- Owner 2 changes req_op/req_addr and drops req during WAIT: bus_op/bus_addr unchanged; cplt[2] still pulses on txn_done.
- txn_done pulsed in IDLE and in BCAST: no state change, no cplt.
- reset asserted during WAIT with owner 1: next cycle gnt=0, cplt=0, rr_ptr=3. Next req=4'b0110 grants requester 1.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=16, no txn_done: RELEASE after 16 WAIT cycles with bus_error=1 and cplt=owner. Repeat with txn_done on cycle 16: bus_error=0.
